spi_slave_rx: RTL and testbench
===============================

# spi_slave_rx

Single-clock SPI mode-0 slave that receives what the SPI master puts on the wire. It oversamples `sclk`, `mosi` and `cs` on the system clock and assembles MSB-first bytes into `rx_data` with a one-cycle `rx_valid` strobe. At the same time it shifts a locally buffered reply byte out on `miso`. It sits directly downstream of the SPI master, on the far end of the serial link, and feeds the byte consumer on the slave side.

## Interface
- `DATA_BITS`, 8, bits per SPI word; the bit counter is $clog2(DATA_BITS) wide.
- `SYNC_STAGES`, 2, flip-flops in each input synchronizer (minimum 2).
- `clk`  in  1  system clock; all logic runs on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `sclk`  in  1  SPI clock from master, asynchronous to `clk`; idles low.
- `mosi`  in  1  serial data from master.
- `cs`  in  1  chip select, active-low.
- `miso`  out  1  serial data to master.
- `tx_data`  in  DATA_BITS  reply byte to queue.
- `tx_load`  in  1  strobe; captures `tx_data` when `tx_ready`=1.
- `tx_ready`  out  1  reply buffer empty and able to accept a byte.
- `tx_underrun`  out  1  one-cycle pulse; a word started with the buffer empty.
- `rx_data`  out  DATA_BITS  last complete received word; held until the next word completes.
- `rx_valid`  out  1  one-cycle pulse; `rx_data` was updated.
- `busy`  out  1  high in state SHIFT.

## Operation
- `sclk`, `mosi` and `cs` each pass through a SYNC_STAGES synchronizer, followed by one history register used for edge detection. All decisions use the synchronized (`_s`) values.
- The state machine has three states: IDLE, SHIFT and WAIT_CS.
  - IDLE → SHIFT on a falling edge of `cs_s`.
  - SHIFT → IDLE on a rising edge of `cs_s`.
  - WAIT_CS → IDLE when `cs_s`=1.
  - `reset` forces WAIT_CS. The block never joins a frame that is already in progress.
- At the start of each word the tx shift register loads, and the reply buffer is consumed:
  - If the buffer is full, the shift register loads the buffer and the buffer empties (`tx_ready`→1).
  - If the buffer is empty, the shift register loads 0 and `tx_underrun` pulses.
  - `miso` = tx_shift[DATA_BITS-1] immediately after the load.
- A word starts at the IDLE→SHIFT transition, and at the first `sclk_s` falling edge after a word completes. This supports multi-word frames with `cs` held low.
- `sclk_s` rising edge in SHIFT:
  - rx_shift <= {rx_shift[DATA_BITS-2:0], mosi_s}; bit_cnt increments.
  - When bit_cnt = DATA_BITS-1: `rx_data` <= the completed word, `rx_valid` pulses, bit_cnt wraps to 0, and the word-complete flag is set.
- `sclk_s` falling edge in SHIFT:
  - If the word-complete flag is set, start a new word.
  - Otherwise shift tx_shift left and present the next bit on `miso`.
- `cs_s` rises mid-word: the partial word is discarded with no `rx_valid`. bit_cnt and the flag clear. The tx byte already loaded is lost, and the buffer is untouched.
- `miso` = 0 whenever the state is not SHIFT.
- Reply buffer:
  - One entry.
  - `tx_load` with `tx_ready`=1 writes the buffer and `tx_ready` drops the next cycle.
  - `tx_load` with `tx_ready`=0 is ignored.
  - `tx_load` in the same cycle as a word start with an empty buffer: the current word still sends 0 with `tx_underrun`, and the loaded byte goes to the next word.
- Mode 0 only, MSB first.

## Timing
- Reset values (on the first rising `clk` edge with `reset`=1):
  - `miso`=0, `rx_data`=0, `rx_valid`=0, `tx_ready`=1, `tx_underrun`=0, `busy`=0.
  - Synchronizers, shift registers and bit_cnt clear; the buffer empties; state = WAIT_CS.
- Latency from a pin edge to the resulting action is SYNC_STAGES+1 `clk` cycles. The first `clk` edge that samples the new pin level counts as cycle 0. This applies to:
  - `rx_valid`, measured from the 8th `sclk` rise;
  - the `miso` update, measured from an `sclk` fall or the `cs` fall;
  - `busy`, measured from the `cs` fall.
- Constraints on the master side:
  - Each `sclk` high or low phase lasts at least SYNC_STAGES+2 `clk` cycles.
  - `cs` fall to first `sclk` rise is at least SYNC_STAGES+3 cycles.
- `rx_valid` and `tx_underrun` are single-cycle pulses. They never stay asserted for two consecutive cycles.

## Test plan
- Single word: release reset with `cs`=1, load `tx_data`=0xA5, then the master sends 0x3C with CLK_DIV=16. Required: `rx_data`=0x3C with one `rx_valid` pulse, `miso` bit sequence 1,0,1,0,0,1,0,1, and `tx_ready`=1 after the `cs` fall.
- Two-word frame: `cs` held low, master sends 0x81 then 0x7E, slave loads 0x11 and then 0x22 after the first consumption. Required: two `rx_valid` pulses with 0x81 then 0x7E; `miso` carries 0x11 then 0x22.
- Underrun: no `tx_load`, master sends 0xFF. Required: `tx_underrun` pulses once at the `cs` fall, `miso` stays 0, `rx_data`=0xFF.
- Abort: `cs` rises after 5 bits of 0xC3. Required: no `rx_valid`, `rx_data` unchanged, and a following full word 0x5A is received correctly.
- Reset mid-frame: assert `reset` after 3 bits with `cs` still low, then release it. Required:
  - all outputs at reset values;
  - remaining `sclk` edges ignored until `cs` goes high;
  - the next frame's byte 0x96 is received correctly.
- `tx_load` while full: load 0x12, then 0x34 with `tx_ready`=0, then run one word. Required: `miso` sends 0x12.

Source files
------------

// File: rtl/spi_slave_rx.sv
// spi_slave_rx
// SPI mode-0 slave (CPOL=0, CPHA=0, MSB first) running entirely on the system
// clock. sclk, mosi and cs are oversampled through synchronizers. Received
// words appear on rx_data with a one-cycle rx_valid strobe. A one-entry reply
// buffer is shifted out on miso, one word per SPI word.
//
// Ports
//   clk          system clock, rising edge
//   reset        synchronous, active-high
//   sclk         SPI clock from master (async, idles low)
//   mosi         serial data from master (async)
//   cs           chip select from master, active-low (async)
//   miso         serial reply to master, 0 whenever not shifting
//   tx_data      reply word to queue
//   tx_load      capture tx_data when tx_ready=1
//   tx_ready     reply buffer empty
//   tx_underrun  one-cycle pulse: a word started with the buffer empty
//   rx_data      last complete received word, held until the next one
//   rx_valid     one-cycle pulse: rx_data updated
//   busy         high while a frame is being shifted
module spi_slave_rx #(
  parameter int DATA_BITS   = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 sclk,
  input  logic                 mosi,
  input  logic                 cs,
  output logic                 miso,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_load,
  output logic                 tx_ready,
  output logic                 tx_underrun,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 busy
);

  localparam int CNT_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SHIFT   = 2'd1,
    WAIT_CS = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [SYNC_STAGES-1:0] sclk_sync_q, mosi_sync_q, cs_sync_q;
  logic                 sclk_hist_q, cs_hist_q;
  logic [CNT_W-1:0]     bit_cnt_q, bit_cnt_d;
  logic                 done_q, done_d;
  logic [DATA_BITS-1:0] rx_shift_q, rx_shift_d;
  logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
  logic                 rx_valid_q, rx_valid_d;
  logic [DATA_BITS-1:0] tx_shift_q, tx_shift_d;
  logic [DATA_BITS-1:0] tx_buf_q, tx_buf_d;
  logic                 tx_full_q, tx_full_d;
  logic                 tx_underrun_q, tx_underrun_d;

  logic sclk_s, mosi_s, cs_s;
  logic sclk_rise, sclk_fall, cs_rise, cs_fall;
  logic in_shift, word_start;

  assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
  assign mosi_s = mosi_sync_q[SYNC_STAGES-1];
  assign cs_s   = cs_sync_q[SYNC_STAGES-1];

  // mosi is only sampled on sclk edges, so it needs no history register.
  assign sclk_rise = sclk_s & ~sclk_hist_q;
  assign sclk_fall = ~sclk_s & sclk_hist_q;
  assign cs_rise   = cs_s & ~cs_hist_q;
  assign cs_fall   = ~cs_s & cs_hist_q;

  // A cs rise aborts the frame and takes priority over any sclk edge.
  assign in_shift   = (state_q == SHIFT) && !cs_rise;
  assign word_start = ((state_q == IDLE) && cs_fall) ||
                      (in_shift && sclk_fall && done_q);

  // State register and all datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= WAIT_CS;
      sclk_sync_q   <= '0;
      mosi_sync_q   <= '0;
      cs_sync_q     <= '0;
      sclk_hist_q   <= 1'b0;
      cs_hist_q     <= 1'b0;
      bit_cnt_q     <= '0;
      done_q        <= 1'b0;
      rx_shift_q    <= '0;
      rx_data_q     <= '0;
      rx_valid_q    <= 1'b0;
      tx_shift_q    <= '0;
      tx_buf_q      <= '0;
      tx_full_q     <= 1'b0;
      tx_underrun_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      sclk_sync_q   <= {sclk_sync_q[SYNC_STAGES-2:0], sclk};
      mosi_sync_q   <= {mosi_sync_q[SYNC_STAGES-2:0], mosi};
      cs_sync_q     <= {cs_sync_q[SYNC_STAGES-2:0], cs};
      sclk_hist_q   <= sclk_s;
      cs_hist_q     <= cs_s;
      bit_cnt_q     <= bit_cnt_d;
      done_q        <= done_d;
      rx_shift_q    <= rx_shift_d;
      rx_data_q     <= rx_data_d;
      rx_valid_q    <= rx_valid_d;
      tx_shift_q    <= tx_shift_d;
      tx_buf_q      <= tx_buf_d;
      tx_full_q     <= tx_full_d;
      tx_underrun_q <= tx_underrun_d;
    end
  end

  // Next state. After reset the block waits for cs high so it never joins a
  // frame that is already running.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (cs_fall) state_d = SHIFT;
      SHIFT:   if (cs_rise) state_d = IDLE;
      WAIT_CS: if (cs_s)    state_d = IDLE;
      default: state_d = WAIT_CS;
    endcase
  end

  // Datapath next-state.
  always_comb begin
    bit_cnt_d     = bit_cnt_q;
    done_d        = done_q;
    rx_shift_d    = rx_shift_q;
    rx_data_d     = rx_data_q;
    rx_valid_d    = 1'b0;
    tx_shift_d    = tx_shift_q;
    tx_buf_d      = tx_buf_q;
    tx_full_d     = tx_full_q;
    tx_underrun_d = 1'b0;

    // Abort: drop the partial word; the reply buffer keeps its contents.
    if ((state_q == SHIFT) && cs_rise) begin
      bit_cnt_d = '0;
      done_d    = 1'b0;
    end

    if (in_shift && sclk_rise) begin
      rx_shift_d = {rx_shift_q[DATA_BITS-2:0], mosi_s};
      if (bit_cnt_q == CNT_W'(DATA_BITS - 1)) begin
        rx_data_d  = rx_shift_d;
        rx_valid_d = 1'b1;
        bit_cnt_d  = '0;
        done_d     = 1'b1;
      end else begin
        bit_cnt_d = bit_cnt_q + CNT_W'(1);
      end
    end

    // The fall after a completed word opens the next word instead of shifting.
    if (in_shift && sclk_fall && !done_q)
      tx_shift_d = {tx_shift_q[DATA_BITS-2:0], 1'b0};

    if (word_start) begin
      done_d = 1'b0;
      if (tx_full_q) begin
        tx_shift_d = tx_buf_q;
        tx_full_d  = 1'b0;
      end else begin
        tx_shift_d    = '0;
        tx_underrun_d = 1'b1;
      end
    end

    // Acceptance looks at the buffer state before this cycle's word start, so
    // a load racing an empty-buffer word start lands in the next word.
    if (tx_load && !tx_full_q) begin
      tx_buf_d  = tx_data;
      tx_full_d = 1'b1;
    end
  end

  // Outputs.
  always_comb begin
    busy = (state_q == SHIFT);
    miso = (state_q == SHIFT) ? tx_shift_q[DATA_BITS-1] : 1'b0;
  end

  assign tx_ready    = ~tx_full_q;
  assign tx_underrun = tx_underrun_q;
  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;

endmodule

// File: tb/tb_spi_slave_rx.sv
// Bench for spi_slave_rx: directed SPI frames from a bench master, an
// event-driven SPI slave model checked against the DUT every cycle, and
// literal expectations for the scenarios of interest.
module tb_spi_slave_rx;

  localparam int S    = 2;  // synchronizer depth
  localparam int HALF = 8;  // sclk half period in clk cycles (CLK_DIV=16)

  logic       clk = 1'b0;
  logic       reset, sclk, mosi, cs, tx_load;
  logic [7:0] tx_data;
  logic       miso, tx_ready, tx_underrun, rx_valid, busy;
  logic [7:0] rx_data;

  always #5 clk = ~clk;

  spi_slave_rx #(.DATA_BITS(8), .SYNC_STAGES(S)) dut (
    .clk(clk), .reset(reset), .sclk(sclk), .mosi(mosi), .cs(cs),
    .miso(miso), .tx_data(tx_data), .tx_load(tx_load), .tx_ready(tx_ready),
    .tx_underrun(tx_underrun), .rx_data(rx_data), .rx_valid(rx_valid),
    .busy(busy)
  );

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;

  // Inputs as the DUT saw them at the last rising edge.
  logic       rst_smp = 1'b1, load_smp = 1'b0;
  logic [7:0] data_smp = 8'h00;
  always @(posedge clk) begin
    cyc      <= cyc + 1;
    rst_smp  <= reset;
    load_smp <= tx_load;
    data_smp <= tx_data;
  end

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cycle=%0d got=%h expected=%h", name, cyc, act, exp);
    end
  endtask

  // Pin events, each tagged with the cycle its effect becomes visible.
  typedef struct {
    int   due;
    logic is_cs;
    logic val;
    logic d;
  } ev_t;
  ev_t evq[$];

  // ---------------- slave model ----------------
  logic       m_active = 1'b0, m_locked = 1'b1, m_in_rst = 1'b0;
  int         m_nbits = 0, m_txi = 0;
  logic [7:0] m_rx = 8'h00, m_rxd = 8'h00, m_tx = 8'h00, m_buf = 8'h00;
  logic       m_full = 1'b0, m_valid = 1'b0, m_under = 1'b0;
  int         n_rxv = 0, n_und = 0;
  logic [7:0] rx_got[$];

  task automatic start_word();
    m_txi = 0;
    if (m_full) begin
      m_tx   = m_buf;
      m_full = 1'b0;
    end else begin
      m_tx    = 8'h00;
      m_under = 1'b1;
    end
  endtask

  initial begin
    ev_t        ev;
    logic       load_ok;
    logic       exp_miso;
    forever begin
      @(negedge clk);
      if (cyc >= 1) begin
        m_valid = 1'b0;
        m_under = 1'b0;
        if (rst_smp) begin
          m_active = 1'b0; m_locked = 1'b1; m_nbits = 0; m_txi = 0;
          m_rx = 8'h00; m_rxd = 8'h00; m_tx = 8'h00; m_buf = 8'h00; m_full = 1'b0;
          evq.delete();
          m_in_rst = 1'b1;
        end else begin
          load_ok = load_smp && !m_full;
          // Synchronizers restart from 0, so a high cs looks like a rise.
          if (m_in_rst) begin
            m_in_rst = 1'b0;
            if (cs) evq.push_back('{due: cyc + S, is_cs: 1'b1, val: 1'b1, d: 1'b0});
          end
          while (evq.size() > 0 && evq[0].due <= cyc) begin
            ev = evq.pop_front();
            if (ev.is_cs) begin
              if (!ev.val) begin
                if (!m_locked && !m_active) begin
                  m_active = 1'b1;
                  m_nbits  = 0;
                  start_word();
                end
              end else if (m_locked) begin
                m_locked = 1'b0;
              end else begin
                m_active = 1'b0;
              end
            end else if (m_active) begin
              if (ev.val) begin
                m_rx = {m_rx[6:0], ev.d};
                m_nbits++;
                if (m_nbits == 8) begin
                  m_rxd   = m_rx;
                  m_valid = 1'b1;
                end
              end else if (m_nbits == 8) begin
                m_nbits = 0;
                start_word();
              end else begin
                m_txi++;
              end
            end
          end
          if (load_ok) begin
            m_buf  = data_smp;
            m_full = 1'b1;
          end
        end
        exp_miso = (m_active && m_txi < 8) ? m_tx[7 - m_txi] : 1'b0;
        chk("miso",        {7'b0, miso},        {7'b0, exp_miso});
        chk("busy",        {7'b0, busy},        {7'b0, m_active});
        chk("tx_ready",    {7'b0, tx_ready},    {7'b0, ~m_full});
        chk("tx_underrun", {7'b0, tx_underrun}, {7'b0, m_under});
        chk("rx_valid",    {7'b0, rx_valid},    {7'b0, m_valid});
        chk("rx_data",     rx_data,             m_rxd);
        if (rx_valid === 1'b1) begin
          n_rxv++;
          rx_got.push_back(rx_data);
        end
        if (tx_underrun === 1'b1) n_und++;
      end
    end
  end

  // ---------------- master ----------------
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_cs(input logic v);
    cs = v;
    evq.push_back('{due: cyc + S + 1, is_cs: 1'b1, val: v, d: 1'b0});
  endtask

  task automatic drive_sclk(input logic v);
    sclk = v;
    evq.push_back('{due: cyc + S + 1, is_cs: 1'b0, val: v, d: mosi});
  endtask

  task automatic load(input logic [7:0] v);
    tx_data = v;
    tx_load = 1'b1;
    step(1);
    tx_load = 1'b0;
  endtask

  // Sends b[7] down to b[8-nbits]; got collects miso as seen at each rise.
  task automatic send_bits(input logic [7:0] b, input int nbits, output logic [7:0] got);
    got = 8'h00;
    for (int i = 7; i >= 8 - nbits; i--) begin
      mosi = b[i];
      step(HALF);
      got = {got[6:0], miso};
      drive_sclk(1'b1);
      step(HALF);
      drive_sclk(1'b0);
    end
  endtask

  task automatic end_frame();
    step(HALF);
    drive_cs(1'b1);
    step(2 * HALF);
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_miso"},     {7'b0, miso},        8'h00);
    chk({tag, "_rx_data"},  rx_data,             8'h00);
    chk({tag, "_rx_valid"}, {7'b0, rx_valid},    8'h00);
    chk({tag, "_tx_ready"}, {7'b0, tx_ready},    8'h01);
    chk({tag, "_underrun"}, {7'b0, tx_underrun}, 8'h00);
    chk({tag, "_busy"},     {7'b0, busy},        8'h00);
  endtask

  initial begin
    logic [7:0] got, got2;
    int         r0, u0;
    reset = 1'b1; cs = 1'b1; sclk = 1'b0; mosi = 1'b0;
    tx_load = 1'b0; tx_data = 8'h00;
    step(4);
    chk_reset_values("rst");
    reset = 1'b0;
    step(2 * HALF);

    // Single word: reply A5, receive 3C.
    load(8'hA5);
    chk("t1_ready_after_load", {7'b0, tx_ready}, 8'h00);
    r0 = n_rxv;
    drive_cs(1'b0);
    step(S);
    chk("t1_busy_early", {7'b0, busy}, 8'h00);
    step(1);
    chk("t1_busy_on_time", {7'b0, busy},     8'h01);
    chk("t1_ready_consumed", {7'b0, tx_ready}, 8'h01);
    chk("t1_miso_msb",   {7'b0, miso},     8'h01);
    send_bits(8'h3C, 8, got);
    step(HALF);
    chk("t1_miso_word", got,     8'hA5);
    chk("t1_rx_data",   rx_data, 8'h3C);
    chk("t1_rx_pulses", 8'(n_rxv - r0), 8'd1);
    drive_cs(1'b1);
    step(2 * HALF);

    // Two-word frame: receive 81, 7E; reply 11, 22.
    rx_got.delete();
    load(8'h11);
    drive_cs(1'b0);
    step(4);
    chk("t2_ready_consumed", {7'b0, tx_ready}, 8'h01);
    load(8'h22);
    send_bits(8'h81, 8, got);
    send_bits(8'h7E, 8, got2);
    end_frame();
    chk("t2_miso_w0", got,  8'h11);
    chk("t2_miso_w1", got2, 8'h22);
    chk("t2_rx_count", 8'(rx_got.size()), 8'd2);
    if (rx_got.size() == 2) begin
      chk("t2_rx_w0", rx_got[0], 8'h81);
      chk("t2_rx_w1", rx_got[1], 8'h7E);
    end

    // Underrun: empty buffer, receive FF.
    u0 = n_und;
    drive_cs(1'b0);
    step(S + 1);
    chk("t3_underrun_pulse", {7'b0, tx_underrun}, 8'h01);
    step(1);
    chk("t3_underrun_single", {7'b0, tx_underrun}, 8'h00);
    send_bits(8'hFF, 8, got);
    chk("t3_underrun_count", 8'(n_und - u0), 8'd1);
    chk("t3_miso_zero", got, 8'h00);
    end_frame();
    chk("t3_rx_data", rx_data, 8'hFF);

    // Abort after 5 bits of C3, then a full 5A.
    r0 = n_rxv;
    drive_cs(1'b0);
    send_bits(8'hC3, 5, got);
    end_frame();
    chk("t4_abort_no_valid", 8'(n_rxv - r0), 8'd0);
    chk("t4_abort_rx_held",  rx_data, 8'hFF);
    drive_cs(1'b0);
    send_bits(8'h5A, 8, got);
    end_frame();
    chk("t4_rx_after_abort", rx_data, 8'h5A);
    chk("t4_rx_pulses", 8'(n_rxv - r0), 8'd1);

    // Reset after 3 bits with cs low; rest of frame ignored; then 96.
    drive_cs(1'b0);
    send_bits(8'hE7, 3, got);
    step(2);
    reset = 1'b1;
    step(3);
    chk_reset_values("t5_rst");
    reset = 1'b0;
    r0 = n_rxv;
    step(2);
    send_bits(8'hFF, 5, got);
    chk("t5_ignored_busy", {7'b0, busy}, 8'h00);
    end_frame();
    chk("t5_ignored_valid", 8'(n_rxv - r0), 8'd0);
    chk("t5_rx_still_reset", rx_data, 8'h00);
    load(8'h3A);
    drive_cs(1'b0);
    send_bits(8'h96, 8, got);
    end_frame();
    chk("t5_rx_data", rx_data, 8'h96);
    chk("t5_miso_word", got, 8'h3A);

    // tx_load while full is ignored.
    load(8'h12);
    chk("t6_ready_low", {7'b0, tx_ready}, 8'h00);
    load(8'h34);
    chk("t6_ready_still_low", {7'b0, tx_ready}, 8'h00);
    drive_cs(1'b0);
    send_bits(8'hC6, 8, got);
    end_frame();
    chk("t6_miso_word", got, 8'h12);
    chk("t6_rx_data", rx_data, 8'hC6);

    step(10);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached before end of stimulus");
    $fatal(1, "time limit");
  end

endmodule
